// File: rtl/frame_align_pkg.sv
// Shared types and constants for the frame-word alignment controller.
package frame_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_e;

  localparam logic [15:0] DEF_PATTERN = 16'hFF00;
  localparam logic [15:0] DEF_MASK    = 16'hFFFF;
  localparam int          CNT_W       = 8;
  localparam int          SETTLE_W    = 4;

endpackage

// File: rtl/frame_align_ctl.sv
// Frame-word alignment controller: slips the ISERDES2 phy until the frame
// word matches the expected pattern, then holds lock and watches for its loss.
module frame_align_ctl
  import frame_align_pkg::*;
#(
  parameter logic [15:0] PATTERN       = DEF_PATTERN,
  parameter logic [15:0] MASK          = DEF_MASK,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned LOCK_COUNT    = 16,
  parameter int unsigned LOSS_COUNT    = 4,
  parameter int unsigned MAX_SLIPS     = 16
) (
  input  logic             clkdiv,
  input  logic             reset,
  input  logic             enable,
  input  logic             retry,
  input  logic [15:0]      frame_in,
  output logic             bitslip,
  output logic             locked,
  output logic             align_err,
  output logic [CNT_W-1:0] slip_count,
  output logic             lock_lost
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [CNT_W-1:0]    LOCK_LAST   = CNT_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W-1:0]    LOSS_LAST   = CNT_W'(LOSS_COUNT - 1);
  localparam logic [CNT_W-1:0]    SLIP_MAX    = CNT_W'(MAX_SLIPS);
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]    slip_count_q, slip_count_d;
  logic                lock_lost_d;
  logic                match_q, bitslip_q, locked_q, align_err_q, lock_lost_q;

  // Next-state and counter logic; decisions use the registered compare.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    run_cnt_d    = run_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    slip_count_d = slip_count_q;
    lock_lost_d  = 1'b0;
    if (!enable) begin
      state_d      = ST_IDLE;
      settle_cnt_d = '0;
      run_cnt_d    = '0;
      miss_cnt_d   = '0;
      slip_count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d      = ST_CHECK;
            settle_cnt_d = '0;
            run_cnt_d    = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + SETTLE_ONE;
          end
        end
        ST_CHECK: begin
          if (match_q) begin
            run_cnt_d = run_cnt_q + CNT_ONE;
            if (run_cnt_q == LOCK_LAST) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = '0;
            end else begin
              state_d = ST_CHECK;
            end
          end else if (slip_count_q < SLIP_MAX) begin
            state_d      = ST_SLIP;
            run_cnt_d    = '0;
            slip_count_d = slip_count_q + CNT_ONE;
          end else begin
            state_d   = ST_FAIL;
            run_cnt_d = '0;
          end
        end
        ST_SLIP: begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
        ST_LOCKED: begin
          // An explicit retry wins over a simultaneous loss of lock.
          if (retry) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
            miss_cnt_d   = '0;
            slip_count_d = '0;
          end else if (match_q) begin
            miss_cnt_d = '0;
          end else if (miss_cnt_q == LOSS_LAST) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
            miss_cnt_d   = '0;
            slip_count_d = '0;
            lock_lost_d  = 1'b1;
          end else begin
            miss_cnt_d = miss_cnt_q + CNT_ONE;
          end
        end
        ST_FAIL: begin
          if (retry) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
            slip_count_d = '0;
          end else begin
            state_d = ST_FAIL;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          settle_cnt_d = '0;
          run_cnt_d    = '0;
          miss_cnt_d   = '0;
          slip_count_d = '0;
        end
      endcase
    end
  end

  // State, counters, compare register and registered outputs.
  always_ff @(posedge clkdiv) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      run_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      slip_count_q <= '0;
      match_q      <= 1'b0;
      bitslip_q    <= 1'b0;
      locked_q     <= 1'b0;
      align_err_q  <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      run_cnt_q    <= run_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      slip_count_q <= slip_count_d;
      match_q      <= ((frame_in & MASK) == (PATTERN & MASK));
      bitslip_q    <= (state_d == ST_SLIP);
      locked_q     <= (state_d == ST_LOCKED);
      align_err_q  <= (state_d == ST_FAIL);
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign locked     = locked_q;
  assign align_err  = align_err_q;
  assign slip_count = slip_count_q;
  assign lock_lost  = lock_lost_q;

endmodule
